l64_adder_arbiter: RTL and testbench

L64_ADDER_ARBITER -- requirements
Module: l64_adder_arbiter

---
 rtl/l64_adder_arbiter.sv | 150 +++++++++++++++
 tb/tb_l64_adder_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l64_adder_arbiter.sv
// l64_adder_arbiter
//   Round-robin arbiter in front of one shared 64-bit end-around-carry adder.
//   Two pipeline stages: S0 issue register feeding the adder, S1 result register.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : [NREQ]      requester i presents an operand pair
//   req_ready  : [NREQ]      requester i's pair accepted this cycle (one-hot or zero)
//   req_a      : [64*NREQ]   operand A, slice [64*i +: 64] per requester
//   req_b      : [64*NREQ]   operand B, same slicing
//   rsp_valid  : result available
//   rsp_ready  : consumer accepts result
//   rsp_sum    : modulo-(2^64-1) sum (all-ones kept as-is)
//   rsp_id     : requester index owning rsp_sum
//   busy       : any pipeline stage valid
//
// Parameters
//   NREQ : number of requesters (2, 4 or 8)
//   IDW  : requester-ID width, must equal log2(NREQ)

// Combinational end-around-carry adder.
module L64_adder (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic [63:0] o_sum
);
  logic [64:0] w_s;

  assign w_s   = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = w_s[63:0] + {63'd0, w_s[64]};
endmodule

module l64_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  // S0 issue register
  logic            r_v0;
  logic [63:0]     r_a0;
  logic [63:0]     r_b0;
  logic [IDW-1:0]  r_id0;
  // S1 result register
  logic            r_v1;
  logic [63:0]     r_sum1;
  logic [IDW-1:0]  r_id1;
  // round-robin search start
  logic [IDW-1:0]  r_rr;

  logic            w_load1;
  logic            w_load0;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_idx;
  logic            w_accept;
  logic [63:0]     w_sel_a;
  logic [63:0]     w_sel_b;
  logic [63:0]     w_sum;

  // Stage advance: S1 frees when empty or draining; S0 may load whenever S1 does.
  assign w_load1 = !r_v1 || rsp_ready;
  assign w_load0 = !r_v0 || w_load1;

  // First valid requester found searching upward from r_rr, wrapping at NREQ.
  // NREQ is a power of two, so IDW-bit addition wraps modulo NREQ.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = r_rr + IDW'(k);
      if (!w_gnt_any && req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  assign w_accept = w_gnt_any && w_load0;

  // Ready is gated by rst_n so that it reads zero throughout reset even though
  // the empty pipeline would otherwise allow a grant.
  always_comb begin
    req_ready = '0;
    if (w_accept && rst_n) begin
      req_ready[w_gnt_id] = 1'b1;
    end
  end

  // {id, 6'd0} is id*64, the base of the requester's operand slice.
  assign w_sel_a = req_a[{w_gnt_id, 6'd0} +: 64];
  assign w_sel_b = req_b[{w_gnt_id, 6'd0} +: 64];

  L64_adder u_adder (
    .i_a   (r_a0),
    .i_b   (r_b0),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0   <= 1'b0;
      r_a0   <= '0;
      r_b0   <= '0;
      r_id0  <= '0;
      r_v1   <= 1'b0;
      r_sum1 <= '0;
      r_id1  <= '0;
      r_rr   <= '0;
    end else begin
      if (w_load0) begin
        r_v0 <= w_accept;
        if (w_accept) begin
          r_a0  <= w_sel_a;
          r_b0  <= w_sel_b;
          r_id0 <= w_gnt_id;
        end
      end
      if (w_load1) begin
        r_v1 <= r_v0;
        if (r_v0) begin
          r_sum1 <= w_sum;
          r_id1  <= r_id0;
        end
      end
      if (w_accept) begin
        r_rr <= w_gnt_id + IDW'(1);
      end
    end
  end

  assign rsp_valid = r_v1;
  assign rsp_sum   = r_sum1;
  assign rsp_id    = r_id1;
  assign busy      = r_v0 | r_v1;

endmodule

// File: tb/tb_l64_adder_arbiter.sv
// Testbench for l64_adder_arbiter: directed steps followed by a random phase,
// with a reference pipeline/arbiter model and a scoreboard of expected results.
module tb_l64_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [64*NREQ-1:0]  req_a;
  logic [64*NREQ-1:0]  req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [63:0]         rsp_sum;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  l64_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]    sum;
    logic [IDW-1:0] id;
  } ent_t;

  ent_t            sb[$];       // entries in pipeline order, front = oldest
  int unsigned     glog[$];     // granted indices, in acceptance order
  bit              m_v0, m_v1;
  logic [IDW-1:0]  m_rr;
  logic [NREQ-1:0] exp_ready;
  bit              exp_any;
  int unsigned     exp_gid;
  bit              m_acc;
  int unsigned     m_accid;
  int unsigned     waitc[NREQ];
  int              n_assert;
  int              n_fail;
  int              mode;          // 0: drop valid on accept, 1: refill on accept, 2: random
  bit              rand_rdy;
  logic [63:0]     held_sum;
  logic [IDW-1:0]  held_id;
  int unsigned     exp_order[6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // End-around carry: a wrapped 64-bit sum smaller than an operand means carry-out.
  function automatic logic [63:0] eac(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] t;
    t = a + b;
    return (t < a) ? t + 64'd1 : t;
  endfunction

  task automatic set_data(input int unsigned i);
    logic [63:0] a;
    logic [63:0] b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: b = ~a;
      1: begin a = '1; b = 64'd1; end
      2: b = 64'd0;
      default: ;
    endcase
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
  endtask

  // Compare DUT against the model; called at the falling edge.
  task automatic check_cycle();
    bit l1, l0;
    if (!rst_n) begin
      exp_any = 1'b0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_sum", rsp_sum, 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end else begin
      exp_any = 1'b0;
      exp_gid = 0;
      for (int k = 0; k < NREQ; k++) begin
        int unsigned j;
        j = (int'(m_rr) + k) % NREQ;
        if (!exp_any && req_valid[j]) begin
          exp_any = 1'b1;
          exp_gid = j;
        end
      end
      l1 = !m_v1 || rsp_ready;
      l0 = !m_v0 || l1;
      exp_ready = '0;
      if (exp_any && l0) exp_ready[exp_gid] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_v1));
      chk("busy", 64'(busy), 64'(m_v0 | m_v1));
      if (m_v1 && sb.size() > 0) begin
        chk("rsp_sum", rsp_sum, sb[0].sum);
        chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
      end
    end
  endtask

  // Advance the model across the rising edge.
  task automatic advance();
    bit l1, l0;
    ent_t e;
    m_acc = 1'b0;
    if (!rst_n) begin
      sb.delete();
      m_v0 = 1'b0;
      m_v1 = 1'b0;
      m_rr = '0;
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else begin
      l1 = !m_v1 || rsp_ready;
      l0 = !m_v0 || l1;
      m_acc = exp_any && l0;
      m_accid = exp_gid;
      if (l1 && m_v1) void'(sb.pop_front());
      if (l1) m_v1 = m_v0;
      if (l0) m_v0 = m_acc;
      if (m_acc) begin
        e.sum = eac(req_a[64*exp_gid +: 64], req_b[64*exp_gid +: 64]);
        e.id  = IDW'(exp_gid);
        sb.push_back(e);
        glog.push_back(exp_gid);
        m_rr = IDW'(exp_gid + 1);
        for (int i = 0; i < NREQ; i++) begin
          if (i == int'(exp_gid)) begin
            waitc[i] = 0;
          end else if (req_valid[i]) begin
            waitc[i]++;
            chk($sformatf("fair_wait%0d", i), 64'(waitc[i] < NREQ), 64'd1);
          end else begin
            waitc[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic drive_next();
    if (rst_n && m_acc) begin
      if (mode == 1) set_data(m_accid);
      else req_valid[m_accid] = 1'b0;
    end
    if (mode == 2) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          set_data(i);
        end
      end
    end
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    advance();
    #1;
    drive_next();
  endtask

  task automatic drain();
    mode = 0;
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 64 && (req_valid != '0 || sb.size() != 0); c++) step();
    chk("drain_left", 64'(sb.size()) + 64'(req_valid != '0), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    mode = 0;
    rand_rdy = 1'b0;
    m_v0 = 1'b0;
    m_v1 = 1'b0;
    m_rr = '0;
    m_acc = 1'b0;
    m_accid = 0;
    exp_any = 1'b0;
    exp_gid = 0;
    exp_ready = '0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;

    // Reset state
    #2;
    chk("init_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    step();
    step();

    // All requesters continuously valid: grant order 0,1,2,3,0,1
    rst_n = 1'b1;
    mode = 1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_data(i);
    glog.delete();
    repeat (6) step();
    exp_order = '{0, 1, 2, 3, 0, 1};
    chk("grant_count", 64'(glog.size()), 64'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++)
      chk($sformatf("grant_order%0d", k), 64'(glog[k]), 64'(exp_order[k]));
    drain();

    // Single requester, end-around carry cases
    mode = 0;
    req_a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b[63:0] = 64'h0000_0000_0000_0001;
    req_valid = 4'b0001;
    step();
    step();
    chk("eac_ones_plus1_valid", 64'(rsp_valid), 64'd1);
    chk("eac_ones_plus1_sum", rsp_sum, 64'h0000_0000_0000_0001);
    chk("eac_ones_plus1_id", 64'(rsp_id), 64'd0);
    req_a[63:0] = 64'hAAAA_AAAA_AAAA_AAAA;
    req_b[63:0] = 64'h5555_5555_5555_5555;
    req_valid = 4'b0001;
    step();
    step();
    chk("eac_allones_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    req_a[63:0] = 64'h8000_0000_0000_0000;
    req_b[63:0] = 64'h8000_0000_0000_0000;
    req_valid = 4'b0001;
    step();
    step();
    chk("eac_msb_sum", rsp_sum, 64'h0000_0000_0000_0001);
    drain();

    // Fill the pipeline, then stall the consumer for 5 cycles
    mode = 1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_data(i);
    step();
    step();
    rsp_ready = 1'b0;
    held_sum = rsp_sum;
    held_id = rsp_id;
    repeat (5) begin
      step();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_sum", rsp_sum, held_sum);
      chk("stall_id", 64'(rsp_id), 64'(held_id));
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    step();
    step();

    // Reset with both stages valid
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_sum", rsp_sum, 64'd0);
    step();
    rst_n = 1'b1;
    mode = 0;
    req_valid = 4'b1010;
    set_data(1);
    set_data(3);
    #1;
    chk("post_reset_grant", 64'(req_ready), 64'h2);
    step();
    drain();

    // Random traffic with backpressure
    mode = 2;
    rand_rdy = 1'b1;
    repeat (10000) step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
